// File: rtl/int_mul_tiled_pkg.sv
// Shared constants and sizing helpers for the tiled integer multiplier.
// Latency bookkeeping lives here so the pipeline top can sum its stages.
package int_mul_tiled_pkg;

  localparam int TILE_A_W = 26;
  localparam int TILE_B_W = 17;
  localparam int TILE_P_W = TILE_A_W + TILE_B_W;

  typedef struct packed {
    int ff_in;
    int ff_mul;
    int depth;
    int ff_out;
  } int_mul_params_t;

  function automatic int int_mul_na(input int logq);
    return (logq + TILE_A_W - 1) / TILE_A_W;
  endfunction

  function automatic int int_mul_nb(input int logq);
    return (logq + TILE_B_W - 1) / TILE_B_W;
  endfunction

  function automatic int int_mul_tree_depth(input int logq);
    return $clog2(int_mul_na(logq) * int_mul_nb(logq));
  endfunction

  function automatic int_mul_params_t int_mul_params(
    input int logq,
    input int ff_in,
    input int ff_mul
  );
    int_mul_params_t p;
    p.ff_in  = ff_in;
    p.ff_mul = ff_mul;
    p.depth  = int_mul_tree_depth(logq);
    p.ff_out = 1;
    return p;
  endfunction

  function automatic int int_mul_lat(
    input int logq,
    input int ff_in,
    input int ff_mul
  );
    int_mul_params_t p;
    p = int_mul_params(logq, ff_in, ff_mul);
    return p.ff_in + p.ff_mul + p.depth + p.ff_out;
  endfunction

endpackage

// File: rtl/int_mul_tiled_dsp_tile_mul.sv
// 26x17 unsigned multiply tile with FF_MUL pipeline registers (one DSP48).
// Data-only path: no reset, so the registers can pack into the DSP.
module dsp_tile_mul
  import int_mul_tiled_pkg::*;
#(
  parameter int FF_MUL = 1
) (
  input  logic                clk,
  input  logic [TILE_A_W-1:0] a_i,
  input  logic [TILE_B_W-1:0] b_i,
  output logic [TILE_P_W-1:0] p_o
);

  logic [TILE_P_W-1:0] p_q;

  if (FF_MUL >= 2) begin : g_ff2
    logic [TILE_A_W-1:0] a_q;
    logic [TILE_B_W-1:0] b_q;
    always_ff @(posedge clk) begin
      a_q <= a_i;
      b_q <= b_i;
      p_q <= TILE_P_W'(a_q) * TILE_P_W'(b_q);
    end
  end else begin : g_ff1
    always_ff @(posedge clk) begin
      p_q <= TILE_P_W'(a_i) * TILE_P_W'(b_i);
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/int_mul_tiled.sv
// Pipelined LOGQ x LOGQ multiplier from 26x17 tiles with a registered adder tree.
// Optional INT_MUL_TILED_TAG_EN adds an in_tag/out_tag side channel.
module int_mul_tiled
  import int_mul_tiled_pkg::*;
#(
  parameter int LOGQ    = 60,
  parameter int QH_MODE = 1,
  parameter int FF_IN   = 1,
  parameter int FF_MUL  = 1,
`ifdef INT_MUL_TILED_TAG_EN
  parameter int TAG_W   = 8,
`endif
  localparam int LOGQH  = (QH_MODE == 0) ? 26 : 17,
  localparam int K      = 2 * LOGQ,
  localparam int LAT    = int_mul_lat(LOGQ, FF_IN, FF_MUL),
  localparam int CW     = $clog2(LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LOGQ-1:0]  a,
  input  logic [LOGQ-1:0]  b,
  input  logic [LOGQH-1:0] qH_in,
`ifdef INT_MUL_TILED_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  output logic [K-1:0]     C,
  output logic [LOGQH-1:0] qH_out,
  output logic [CW-1:0]    inflight,
  output logic             idle
);

  localparam int NA  = int_mul_na(LOGQ);
  localparam int NB  = int_mul_nb(LOGQ);
  localparam int D   = int_mul_tree_depth(LOGQ);
  localparam int NP  = 1 << D;
  localparam int K1  = K + 1;
  localparam int AXW = NA * TILE_A_W;
  localparam int BXW = NB * TILE_B_W;

  logic [LOGQ-1:0] a_s;
  logic [LOGQ-1:0] b_s;

  if (FF_IN != 0) begin : g_ffin
    logic [LOGQ-1:0] a_q;
    logic [LOGQ-1:0] b_q;
    always_ff @(posedge clk) begin
      a_q <= a;
      b_q <= b;
    end
    assign a_s = a_q;
    assign b_s = b_q;
  end else begin : g_noffin
    assign a_s = a;
    assign b_s = b;
  end

  logic [AXW-1:0] a_x;
  logic [BXW-1:0] b_x;

  assign a_x = AXW'(a_s);
  assign b_x = BXW'(b_s);

  logic [TILE_P_W-1:0] prod [NA*NB];

  for (genvar i = 0; i < NA; i++) begin : g_a
    for (genvar j = 0; j < NB; j++) begin : g_b
      dsp_tile_mul #(
        .FF_MUL (FF_MUL)
      ) u_tile (
        .clk (clk),
        .a_i (a_x[i*TILE_A_W +: TILE_A_W]),
        .b_i (b_x[j*TILE_B_W +: TILE_B_W]),
        .p_o (prod[i*NB+j])
      );
    end
  end

  // Partial products stay below 2^K, so K+1 bits never overflow.
  logic [K1-1:0] leaf [NP];

  always_comb begin
    for (int n = 0; n < NP; n++) begin
      leaf[n] = '0;
    end
    for (int i = 0; i < NA; i++) begin
      for (int j = 0; j < NB; j++) begin
        leaf[i*NB+j] = K1'(prod[i*NB+j])
                       << (TILE_A_W*i + TILE_B_W*j);
      end
    end
  end

  logic [K1-1:0] sum;

  if (D == 0) begin : g_notree
    assign sum = leaf[0];
  end else begin : g_tree
    logic [K1-1:0] lvl_q [D][NP];
    always_ff @(posedge clk) begin
      for (int n = 0; n < NP; n++) begin
        if (n < NP/2) begin
          lvl_q[0][n] <= leaf[2*n] + leaf[2*n+1];
        end else begin
          lvl_q[0][n] <= '0;
        end
      end
      for (int l = 1; l < D; l++) begin
        for (int n = 0; n < NP; n++) begin
          if (n < NP/2) begin
            lvl_q[l][n] <= lvl_q[l-1][2*n] + lvl_q[l-1][2*n+1];
          end else begin
            lvl_q[l][n] <= '0;
          end
        end
      end
    end
    assign sum = lvl_q[D-1][0];
  end

  logic unused_sum_msb;
  assign unused_sum_msb = sum[K];

  logic [K-1:0] c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= sum[K-1:0];
    end
  end

  assign C = c_q;

  // Side-band delay line matching the data path depth.
  logic [LAT-1:0]   v_q;
  logic [LOGQH-1:0] qh_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int n = 0; n < LAT; n++) begin
        qh_q[n] <= '0;
      end
    end else begin
      v_q     <= {v_q[LAT-2:0], in_valid};
      qh_q[0] <= qH_in;
      for (int n = 1; n < LAT; n++) begin
        qh_q[n] <= qh_q[n-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign qH_out    = qh_q[LAT-1];

`ifdef INT_MUL_TILED_TAG_EN
  logic [TAG_W-1:0] tag_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < LAT; n++) begin
        tag_q[n] <= '0;
      end
    end else begin
      tag_q[0] <= in_tag;
      for (int n = 1; n < LAT; n++) begin
        tag_q[n] <= tag_q[n-1];
      end
    end
  end

  assign out_tag = tag_q[LAT-1];
`endif

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      in_valid && !out_valid: cnt_d = cnt_q + CW'(1);
      !in_valid && out_valid: cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign inflight = cnt_q;
  assign idle     = (cnt_q == '0) && !in_valid;

endmodule

// File: tb/tb_int_mul_tiled.sv
// Scoreboard bench for int_mul_tiled: random and directed ops vs a*b model.
// Second instance covers the single-tile LOGQ=17 configuration.
`timescale 1ns/1ps
module tb_int_mul_tiled;

  localparam int LQ  = 60;
  localparam int LAT = 7;
  localparam int K   = 120;
  localparam int QW  = 17;
  localparam int SLQ = 17;
  localparam int SK  = 34;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [LQ-1:0] a = '0;
  logic [LQ-1:0] b = '0;
  logic [QW-1:0] qh = '0;
  logic          out_valid;
  logic [K-1:0]  c;
  logic [QW-1:0] qh_o;
  logic [2:0]    inflight;
  logic          idle;

  logic           s_iv = 1'b0;
  logic [SLQ-1:0] sa = '0;
  logic [SLQ-1:0] sb = '0;
  logic [QW-1:0]  sq = '0;
  logic           s_ov;
  logic [SK-1:0]  s_c;
  logic [QW-1:0]  s_qo;
  logic [1:0]     s_inflight;
  logic           s_idle;

  int_mul_tiled #(
    .LOGQ(LQ), .QH_MODE(1), .FF_IN(1), .FF_MUL(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .qH_in(qh),
    .out_valid(out_valid), .C(c), .qH_out(qh_o),
    .inflight(inflight), .idle(idle)
  );

  int_mul_tiled #(
    .LOGQ(SLQ), .QH_MODE(1), .FF_IN(0), .FF_MUL(2)
  ) sdut (
    .clk(clk), .rst(rst), .in_valid(s_iv),
    .a(sa), .b(sb), .qH_in(sq),
    .out_valid(s_ov), .C(s_c), .qH_out(s_qo),
    .inflight(s_inflight), .idle(s_idle)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [K-1:0]  c;
    logic [QW-1:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   cyc = 0;
  int   max_if = 0;

  // Reference: every accepted op yields a*b and its qH, LAT cycles later.
  initial begin : model
    logic [K-1:0] ea;
    logic [K-1:0] eb;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        hist.delete();
      end else if (in_valid) begin
        ea = K'(a);
        eb = K'(b);
        exp_q.push_back('{ea * eb, qh});
        hist.push_back(cyc);
      end
      cyc++;
    end
  end

  initial begin : monitor
    int   n_exp;
    logic ev;
    exp_t e;
    forever begin
      @(negedge clk);
      n_exp = 0;
      ev = 1'b0;
      foreach (hist[i]) begin
        if (hist[i] >= cyc - LAT) n_exp++;
        if (hist[i] == cyc - LAT) ev = 1'b1;
      end
      while (hist.size() > 0 && hist[0] < cyc - LAT)
        void'(hist.pop_front());
      chk("inflight", inflight, n_exp);
      chk("out_valid", out_valid, ev);
      chk("idle", idle, (n_exp == 0) && !in_valid);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("C", c, e.c);
          chk("qH_out", qh_o, e.q);
        end
      end
      if (int'(inflight) > max_if) max_if = int'(inflight);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [LQ-1:0] va, input logic [LQ-1:0] vb,
                       input logic [QW-1:0] vq);
    in_valid = 1'b1;
    a = va;
    b = vb;
    qh = vq;
    step();
    in_valid = 1'b0;
  endtask

  initial begin : stim
    int lat;
    int cnt;
    logic [LQ-1:0] ones;
    ones = '1;

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_C", c, 0);
    chk("rst_qH", qh_o, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_idle", idle, 1);
    step();

    issue(ones, ones, 17'h1ABCD);
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        chk("single_C", c, 120'hFFFFFFFFFFFFFFE000000000000001);
        chk("single_qH", qh_o, 17'h1ABCD);
      end
    end
    chk("single_latency", lat, LAT);
    repeat (3) step();

    issue('0, 60'd12345, 17'h00001);
    issue(60'd1, ones, 17'h00002);
    repeat (10) step();

    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("coincide_hold", inflight, 1);
    repeat (10) step();

    max_if = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      a = LQ'({$urandom, $urandom});
      b = LQ'({$urandom, $urandom});
      qh = QW'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();
    chk("inflight_sat", max_if, LAT);

    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = LQ'({$urandom, $urandom});
      b = LQ'({$urandom, $urandom});
      qh = QW'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();

    issue(60'h123456789ABCDEF, 60'hFEDCBA987654321, 17'h0AAAA);
    issue(60'h0F0F0F0F0F0F0F0, 60'h00000FFFFFFFFFF, 17'h05555);
    rst = 1'b1;
    in_valid = 1'b1;
    a = ones;
    b = ones;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_C", c, 0);
    chk("midrst_qH", qh_o, 0);
    chk("midrst_inflight", inflight, 0);
    chk("midrst_idle", idle, 1);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) cnt++;
    end
    chk("midrst_no_ov", cnt, 0);

    s_iv = 1'b1;
    sa = 17'h1FFFF;
    sb = 17'h1FFFF;
    sq = 17'h0ABCD;
    step();
    s_iv = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("s_inflight", s_inflight, 1);
      if (s_ov === 1'b1) begin
        lat = k;
        chk("s_C", s_c, 34'h3FFFC0001);
        chk("s_qH", s_qo, 17'h0ABCD);
      end
    end
    chk("s_latency", lat, 3);
    repeat (3) step();
    @(negedge clk);
    chk("s_idle", s_idle, 1);

    repeat (12) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/int_mul_tiled.md
Name: int_mul_tiled

Overview:
- Pipelined unsigned LOGQ x LOGQ integer multiplier built from 26x17 DSP tiles.
- Sits directly upstream of the word-level Montgomery reducer: produces the 2*LOGQ-bit product C and a qH value cycle-aligned with it, plus a valid flag.
- Fully pipelined, one operation accepted per cycle, no backpressure (the downstream reducer is fixed-latency).
- Tracks in-flight operations so control logic can detect when the pipeline has drained.

Parameters:
LOGQ, 60, operand width in bits; legal range 17..128.
QH_MODE, 1, 0 -> LOGQH = 26, otherwise LOGQH = 17 (localparam, same encoding as the reducer).
FF_IN, 1, input register stage on a, b, qH_in and in_valid (0 or 1).
FF_MUL, 1, register stages inside each DSP tile product (1 or 2).
K, localparam, 2*LOGQ.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  a, b and qH_in are valid this cycle
a  in  LOGQ  multiplicand
b  in  LOGQ  multiplier
qH_in  in  LOGQH  modulus high word, carried alongside the operands
out_valid  out  1  C and qH_out are valid
C  out  K  product a*b
qH_out  out  LOGQH  qH_in of the same operation
inflight  out  CW  number of accepted operations not yet emitted; CW = clog2(LAT+1)
idle  out  1  inflight == 0 and in_valid == 0

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Tiling:
  - a is split into NA = ceil(LOGQ/26) chunks of 26 bits; b is split into NB = ceil(LOGQ/17) chunks of 17 bits.
  - Top chunks are zero-extended.
  - Each tile computes a 43-bit product, shifted by 26*i + 17*j.
- Adder tree:
  - Binary tree over NA*NB shifted products, D = ceil(log2(NA*NB)) levels.
  - Every level is registered.
  - Widths are K+1 bits internally; the final result is truncated to K bits, which is exact because the product is < 2^K.
- Output register: always present (FF_OUT fixed at 1).
- Latency: LAT = FF_IN + FF_MUL + D + 1. Defaults (LOGQ = 60, NA = 3, NB = 4, D = 4) give LAT = 7.
- Valid and qH alignment:
  - in_valid and qH_in travel through a shift register of depth LAT.
  - out_valid and qH_out emerge in the same cycle as the matching C.
- Throughput: back-to-back in_valid every cycle gives back-to-back out_valid with no bubbles and no reordering.
- Data gating:
  - Data registers do not depend on in_valid; they are free-running.
  - C and qH_out are meaningful only when out_valid = 1.
- inflight counter:
  - in_valid accepted and out_valid both high in the same cycle: hold.
  - in_valid only: increment.
  - out_valid only: decrement.
  - It never exceeds LAT; reaching LAT is legal (pipeline full) and is not an error.
- Reset values:
  - out_valid = 0, inflight = 0, idle = 1 (when in_valid = 0).
  - C = 0, qH_out = 0 (output registers reset).
  - All valid shift-register bits are cleared.
- Reset mid-operation: all in-flight operations are discarded; no out_valid pulse follows reset for operations accepted before it.
- in_valid asserted during rst: ignored.
- Zero operands: C = 0 with out_valid still asserted; there is no special-casing.

Optional Feature:
- Macro: INT_MUL_TILED_TAG_EN.
- When defined:
  - Adds parameter TAG_W (default 8), input in_tag [TAG_W] and output out_tag [TAG_W].
  - out_tag is delayed exactly like qH_out and resets to 0.
- When undefined: the tag ports, the parameter and the tag delay line do not exist.

Decomposition:
- Package int_mul_tiled_pkg holds:
  - TILE_A_W = 26, TILE_B_W = 17.
  - Functions int_mul_na(LOGQ), int_mul_nb(LOGQ), int_mul_tree_depth(LOGQ) and int_mul_lat(LOGQ, FF_IN, FF_MUL).
  - A parameter struct matching the style of the reducer's params type, so the top-level can sum stage latencies.
- One sub-module: dsp_tile_mul, a 26x17 unsigned multiply with FF_MUL internal registers, mapping to one DSP48.

Test Plan:
- Single op, LOGQ = 60: a = 2^60-1, b = 2^60-1, qH_in = 0x1ABCD, one-cycle pulse. Expect out_valid exactly 7 cycles later, C = 2^120 - 2^61 + 1, qH_out = 0x1ABCD, inflight 1 for 7 cycles then 0.
- Streaming: 100 consecutive random (a, b, qH_in) with in_valid held high. Expect 100 consecutive out_valid in order, every C matching the reference model, inflight saturating at 7.
- Zero/one: a = 0, b = 12345 gives C = 0; a = 1, b = 2^60-1 gives C = 2^60-1. Both out_valid = 1.
- Reset mid-stream: 3 ops issued, rst asserted for 1 cycle at cycle 2. Expect no out_valid afterwards, inflight = 0, C = 0, idle = 1.
- Simultaneous accept/emit: in_valid pulses at cycles 0 and 7. Expect inflight = 1 at cycles 1..7, unchanged at the cycle where out_valid and accept coincide.
- LOGQ = 17, FF_IN = 0, FF_MUL = 2 (NA = 1, NB = 1, D = 0): LAT = 3. a = b = 0x1FFFF gives C = 0x3FFFC0001.
